// File: rtl/hubris_program_loader.sv
// Hubris boot front end: packs a byte stream into instruction words,
// then sequences core reset release and the run-cycle watchdog.
module hubris_program_loader #(
  parameter logic [31:0] INST_START_ADDR   = 32'h0,
  parameter int          MEM_SIZE_IN_BYTE  = 4096,
  parameter int          RESET_HOLD_CYCLES = 4,
  parameter int          CYCLE_LIMIT       = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        core_reset,
  input  logic        core_halt,
  output logic        run_done,
  output logic        timeout,
  output logic        load_error,
  output logic [31:0] cycle_count
);

  localparam int WORDS = MEM_SIZE_IN_BYTE / 4;
  localparam int WIW   = $clog2(WORDS + 1);
  localparam int HCW   = (RESET_HOLD_CYCLES > 1) ?
                         $clog2(RESET_HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_LOAD, S_HOLD, S_RUN, S_DONE, S_ERROR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_lane;
  logic [WIW-1:0]  r_word;
  logic [23:0]     r_lanes;
  logic [HCW-1:0]  r_hold;
  logic            r_wr_en;
  logic [31:0]     r_wr_addr;
  logic [31:0]     r_wr_data;
  logic [31:0]     r_count;
  logic            r_done;
  logic            r_to;
  logic            r_err;

  logic            w_accept;
  logic            w_full;
  logic            w_ovf;
  logic            w_flush;
  logic            w_hold_end;
  logic            w_limit;
  logic [31:0]     w_word;

  assign w_accept   = (r_state == S_LOAD) && byte_valid;
  assign w_full     = (r_word == WIW'(WORDS));
  assign w_ovf      = w_accept && w_full;
  assign w_flush    = w_accept && !w_full &&
                      (byte_last || r_lane == 2'd3);
  assign w_hold_end = (r_hold == HCW'(RESET_HOLD_CYCLES - 1));
  assign w_limit    = (r_count == 32'(CYCLE_LIMIT));
  // Lanes above the current one are always clear, so OR-in is enough
  assign w_word     = {8'h0, r_lanes} |
                      ({24'h0, byte_data} << {r_lane, 3'b000});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD: begin
        if (w_ovf)                     w_next = S_ERROR;
        else if (w_flush && byte_last) w_next = S_HOLD;
      end
      S_HOLD: if (w_hold_end) w_next = S_RUN;
      S_RUN:  if (core_halt || w_limit) w_next = S_DONE;
      default: ;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    core_reset = 1'b1;
    unique case (r_state)
      S_LOAD:        byte_ready = 1'b1;
      S_RUN, S_DONE: core_reset = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lane    <= 2'd0;
      r_word    <= '0;
      r_lanes   <= 24'h0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= INST_START_ADDR;
      r_wr_data <= 32'h0;
    end else begin
      r_wr_en <= w_flush;
      if (w_flush) begin
        r_wr_addr <= INST_START_ADDR + (32'(r_word) << 2);
        r_wr_data <= w_word;
        r_word    <= r_word + WIW'(1);
        r_lane    <= 2'd0;
        r_lanes   <= 24'h0;
      end else if (w_accept && !w_full) begin
        r_lane <= r_lane + 2'd1;
        unique case (r_lane)
          2'd0:    r_lanes[7:0]   <= byte_data;
          2'd1:    r_lanes[15:8]  <= byte_data;
          default: r_lanes[23:16] <= byte_data;
        endcase
      end
    end
  end

  // Count stops at CYCLE_LIMIT, so it can never wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold  <= '0;
      r_count <= 32'h0;
      r_done  <= 1'b0;
      r_to    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_HOLD) r_hold <= r_hold + HCW'(1);
      else                   r_hold <= '0;
      if (r_state == S_HOLD && w_hold_end)
        r_count <= 32'd1;
      else if (r_state == S_RUN && !core_halt && !w_limit)
        r_count <= r_count + 32'd1;
      if (r_state == S_RUN && (core_halt || w_limit))
        r_done <= 1'b1;
      if (r_state == S_RUN && !core_halt && w_limit)
        r_to <= 1'b1;
      if (w_ovf)
        r_err <= 1'b1;
    end
  end

  assign mem_wr_en   = r_wr_en;
  assign mem_wr_addr = r_wr_addr;
  assign mem_wr_data = r_wr_data;
  assign run_done    = r_done;
  assign timeout     = r_to;
  assign load_error  = r_err;
  assign cycle_count = r_count;

endmodule
